pkt_attr_extractor: RTL
=======================

Name: pkt_attr_extractor

Overview:
- Passive tap on the 256-bit AXI4-Stream ingress path, upstream of the statistics handler.
- Parses the first 64 bytes of each packet and emits one attribute word per packet with a single-cycle valid pulse.
- The attribute word carries the source-port one-hot, protocol flags, byte length and 5-tuple, laid out exactly as the stats handler consumes them.
- Never applies backpressure.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, stream data width (fixed 256; 32 bytes/beat)
C_M_AXIS_TUSER_WIDTH, 128, tuser width
ATTRIBUTE_DATA_WIDTH, 135, output attribute width
NUM_INPUT_QUEUES, 8, width of source-port one-hot field
TUPLE_WIDTH, 104, 5-tuple field width
BYTES_COUNT_WIDTH, 16, length field width

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous, active-low reset
s_axis_tdata  in  256  packet data; byte k at [8k+7:8k]; multi-byte fields in network order (lower byte index = MSB)
s_axis_tkeep  in  32  byte enables
s_axis_tuser  in  128  [15:0] packet length in bytes, [23:16] source-port one-hot; valid on first beat
s_axis_tvalid  in  1  observed
s_axis_tready  in  1  observed; a beat counts only when tvalid & tready
s_axis_tlast  in  1  last beat
pkt_attributes  out  135  attribute word, registered
pkt_valid  out  1  one-cycle pulse per packet

Behaviour:
- Attribute layout:
  - [134:127] src one-hot (tuser[23:16])
  - [126:125] zero
  - [124] VLAN_AD, [123] VLAN_Q, [122] UDP, [121] TCP, [120] IP
  - [119:104] length (tuser[15:0])
  - [103:72] IPv4 src, [71:40] IPv4 dst, [39:24] L4 src port, [23:8] L4 dst port, [7:0] IP protocol
- Reset: FSM=SOP, buffer cleared, pkt_attributes=0, pkt_valid=0. Reset mid-packet aborts it with no pulse; the next accepted beat after reset is treated as SOP.
- FSM (advances only on accepted beats):
  - SOP: store beat in buf[255:0] and latch tuser[23:0].
    - tlast: clear buf[511:256], raise parse_go, stay in SOP.
    - else: go to BEAT1.
  - BEAT1: store beat in buf[511:256], raise parse_go.
    - tlast: go to SOP.
    - else: go to WAIT_EOP.
  - WAIT_EOP: ignore data; on tlast go to SOP.
- Latency and throughput:
  - parse_go registered; combinational decode of buf in the following cycle; result registered.
  - pkt_valid is high exactly in cycle N+2, where N is the handshake cycle of beat 1, or of beat 0 for single-beat packets.
  - Back-to-back packets, including single-beat ones every cycle, are fully supported: one pulse per packet, in order.
- Field presence: a field is present only if its last byte offset < min(length, 64). Absent fields read 0 and do not set their flags.
- Decode:
  - Tag at bytes 12-13:
    - 0x8100: VLAN_Q=1, L3=18, ethertype at 16.
    - 0x88A8: VLAN_AD=1. If bytes 16-17 = 0x8100 then VLAN_Q=1, L3=22, ethertype at 20; else L3=18, ethertype at 16.
    - otherwise: L3=14, ethertype at 12.
  - IP=1 iff ethertype=0x0800, version nibble=4, IHL>=5, and bytes L3..L3+19 are present.
  - If IP: proto = byte L3+9, src = L3+12..15, dst = L3+16..19.
  - TCP/UDP flags come from proto = 6/17 whenever IP=1.
  - Ports are taken from L4 = L3+4*IHL. Ports are zeroed when L4+3 >= 64, L4+3 >= length, or fragment offset (L3+6..7 & 0x1FFF) is nonzero.
  - Non-IP packets: tuple = 0; VLAN flags still reported.
- Length >= 2^16 cannot occur (tuser field is 16 bits). Length=0 gives all flags 0 and a zeroed tuple, but the pulse is still emitted.

Decomposition:
- Shared package holds:
  - flag bit offsets (FLAG_IP..FLAG_VLAN_AD, derived from TUPLE_WIDTH+BYTES_COUNT_WIDTH)
  - ETH_IPV4=0x0800, ETH_VLAN_Q=0x8100, ETH_VLAN_AD=0x88A8, PROTO_TCP=6, PROTO_UDP=17
  - tuple sub-field offsets
- One sub-module, pkt_hdr_parse: purely combinational; input is a 512-bit buffer plus length; outputs are flags and tuple. It is used by the top (FSM, buffer, output register) and unit-tested alone.

Test Plan:
- 2-beat untagged IPv4/TCP, len 64, src 0x04, 10.0.0.1:1234 -> 10.0.0.2:80 -> one pulse at N+2; attr[134:127]=0x04, flags IP|TCP, len 64, tuple 0x0A000001/0x0A000002/0x04D2/0x0050/0x06.
- 802.1Q+IPv4/UDP, then QinQ (88A8+8100)+IPv4/UDP -> VLAN_Q|IP|UDP for the first; VLAN_AD|VLAN_Q|IP|UDP for the second; ports correct at L3=18/22.
- IPv4 IHL=15 with QinQ (L4=82) and a fragment with offset 0x0010 -> IP|TCP set, ports=0, addresses correct.
- Single-beat 32-byte ARP (0x0806) every cycle for 10 packets, with random tready gaps -> exactly 10 pulses, flags 0, tuple 0, len 32.
- 4-beat packet with tvalid low in beat 1 and an extra tlast stall -> exactly one pulse; beats 2-3 do not alter the attributes.
- resetn asserted low during beat 1 of a packet, then a clean packet -> no pulse for the aborted packet; outputs 0 during reset; clean packet reported correctly.

Source files
------------

// File: rtl/pkt_attr_extractor_pkg.sv
// Shared definitions for the packet attribute extractor.
// Holds stream/attribute widths, the attribute flag bit positions,
// the tuple sub-field offsets, protocol constants, the capture FSM
// state type and a header byte accessor used by the parser.
package pkt_attr_extractor_pkg;

   localparam int C_M_AXIS_DATA_WIDTH  = 256;
   localparam int C_M_AXIS_TUSER_WIDTH = 128;
   localparam int ATTRIBUTE_DATA_WIDTH = 135;
   localparam int NUM_INPUT_QUEUES     = 8;
   localparam int TUPLE_WIDTH          = 104;
   localparam int BYTES_COUNT_WIDTH    = 16;

   // Only the first two beats (64 bytes) of a packet are ever parsed.
   localparam int HDR_BYTES = 64;
   localparam int HDR_WIDTH = 8 * HDR_BYTES;

   // Flag positions inside the parser's flag vector.
   localparam int F_IP      = 0;
   localparam int F_TCP     = 1;
   localparam int F_UDP     = 2;
   localparam int F_VLAN_Q  = 3;
   localparam int F_VLAN_AD = 4;
   localparam int NUM_FLAGS = 5;

   // Flag positions inside the attribute word: directly above length.
   localparam int FLAG_IP      = TUPLE_WIDTH + BYTES_COUNT_WIDTH + F_IP;
   localparam int FLAG_TCP     = TUPLE_WIDTH + BYTES_COUNT_WIDTH + F_TCP;
   localparam int FLAG_UDP     = TUPLE_WIDTH + BYTES_COUNT_WIDTH + F_UDP;
   localparam int FLAG_VLAN_Q  = TUPLE_WIDTH + BYTES_COUNT_WIDTH + F_VLAN_Q;
   localparam int FLAG_VLAN_AD = TUPLE_WIDTH + BYTES_COUNT_WIDTH + F_VLAN_AD;

   // Tuple sub-field LSB offsets.
   localparam int TUPLE_PROTO_LSB = 0;
   localparam int TUPLE_DPORT_LSB = 8;
   localparam int TUPLE_SPORT_LSB = 24;
   localparam int TUPLE_DST_LSB   = 40;
   localparam int TUPLE_SRC_LSB   = 72;

   localparam logic [15:0] ETH_IPV4    = 16'h0800;
   localparam logic [15:0] ETH_VLAN_Q  = 16'h8100;
   localparam logic [15:0] ETH_VLAN_AD = 16'h88A8;
   localparam logic [7:0]  PROTO_TCP   = 8'd6;
   localparam logic [7:0]  PROTO_UDP   = 8'd17;

   typedef enum logic [1:0] {
      ST_SOP      = 2'd0,
      ST_BEAT1    = 2'd1,
      ST_WAIT_EOP = 2'd2
   } cap_state_t;

   // Byte idx of the header buffer, or zero when idx is not below lim.
   // Callers keep lim <= 64, so idx[6] is always clear on a real read.
   function automatic logic [7:0] hdr_byte(input logic [HDR_WIDTH-1:0] hdr,
                                           input logic [6:0] lim,
                                           input logic [6:0] idx);
      logic [7:0] val;
      if (idx < lim) begin
         val = hdr[{idx[5:0], 3'b000} +: 8];
      end else begin
         val = 8'h00;
      end
      return val;
   endfunction

endpackage

// File: rtl/pkt_attr_extractor_hdr_parse.sv
// pkt_hdr_parse: purely combinational L2/L3/L4 header decoder.
// Ports:
//   hdr    in  512  first 64 packet bytes, byte k at [8k+7:8k]
//   length in  16   packet length in bytes
//   flags  out 5    {VLAN_AD, VLAN_Q, UDP, TCP, IP}
//   tuple  out 104  {src ip, dst ip, src port, dst port, proto}
// A field counts only when its last byte lies below min(length, 64);
// absent fields read as zero.
module pkt_hdr_parse
   import pkt_attr_extractor_pkg::*;
(
   input  logic [HDR_WIDTH-1:0]         hdr,
   input  logic [BYTES_COUNT_WIDTH-1:0] length,
   output logic [NUM_FLAGS-1:0]         flags,
   output logic [TUPLE_WIDTH-1:0]       tuple
);

   function automatic logic [15:0] rd16(input logic [HDR_WIDTH-1:0] h,
                                        input logic [6:0] lim,
                                        input logic [6:0] off);
      logic [15:0] val;
      if ((off + 7'd1) < lim) begin
         val = {hdr_byte(h, lim, off), hdr_byte(h, lim, off + 7'd1)};
      end else begin
         val = 16'h0000;
      end
      return val;
   endfunction

   function automatic logic [31:0] rd32(input logic [HDR_WIDTH-1:0] h,
                                        input logic [6:0] lim,
                                        input logic [6:0] off);
      logic [31:0] val;
      if ((off + 7'd3) < lim) begin
         val = {rd16(h, lim, off), rd16(h, lim, off + 7'd2)};
      end else begin
         val = 32'h0000_0000;
      end
      return val;
   endfunction

   logic [6:0]  lim_s;
   logic [15:0] tag_s;
   logic [15:0] inner_s;
   logic [15:0] etype_s;
   logic [6:0]  l3_s;
   logic [6:0]  l4_s;
   logic [7:0]  ver_ihl_s;
   logic [7:0]  proto_s;
   logic [12:0] frag_off_s;
   logic        vlan_q_s;
   logic        vlan_ad_s;
   logic        is_ip_s;
   logic        ports_ok_s;

   // Tag walk, IPv4 qualification and field extraction.
   always_comb begin
      lim_s      = (length > 16'd64) ? 7'd64 : length[6:0];
      tag_s      = rd16(hdr, lim_s, 7'd12);
      inner_s    = rd16(hdr, lim_s, 7'd16);
      vlan_q_s   = 1'b0;
      vlan_ad_s  = 1'b0;
      l3_s       = 7'd14;
      etype_s    = tag_s;
      flags      = {NUM_FLAGS{1'b0}};
      tuple      = {TUPLE_WIDTH{1'b0}};

      case (tag_s)
         ETH_VLAN_Q: begin
            vlan_q_s = 1'b1;
            l3_s     = 7'd18;
            etype_s  = rd16(hdr, lim_s, 7'd16);
         end
         ETH_VLAN_AD: begin
            vlan_ad_s = 1'b1;
            if (inner_s == ETH_VLAN_Q) begin
               vlan_q_s = 1'b1;
               l3_s     = 7'd22;
               etype_s  = rd16(hdr, lim_s, 7'd20);
            end else begin
               l3_s     = 7'd18;
               etype_s  = inner_s;
            end
         end
         default: begin
            l3_s    = 7'd14;
            etype_s = tag_s;
         end
      endcase

      ver_ihl_s  = hdr_byte(hdr, lim_s, l3_s);
      proto_s    = hdr_byte(hdr, lim_s, l3_s + 7'd9);
      frag_off_s = rd16(hdr, lim_s, l3_s + 7'd6) & 16'h1FFF;
      // IHL counts 32-bit words; worst case 22 + 60 = 82 still fits 7 bits.
      l4_s       = l3_s + {1'b0, ver_ihl_s[3:0], 2'b00};

      // The whole 20-byte base header must be visible to trust IP fields.
      is_ip_s    = (etype_s == ETH_IPV4) && (ver_ihl_s[7:4] == 4'd4) &&
                   (ver_ihl_s[3:0] >= 4'd5) && ((l3_s + 7'd19) < lim_s);
      // Non-first fragments carry no L4 header.
      ports_ok_s = is_ip_s && ((l4_s + 7'd3) < lim_s) && (frag_off_s == 13'd0);

      if (is_ip_s) begin
         flags[F_IP]  = 1'b1;
         flags[F_TCP] = (proto_s == PROTO_TCP);
         flags[F_UDP] = (proto_s == PROTO_UDP);
         tuple[TUPLE_SRC_LSB +: 32]  = rd32(hdr, lim_s, l3_s + 7'd12);
         tuple[TUPLE_DST_LSB +: 32]  = rd32(hdr, lim_s, l3_s + 7'd16);
         tuple[TUPLE_PROTO_LSB +: 8] = proto_s;
         if (ports_ok_s) begin
            tuple[TUPLE_SPORT_LSB +: 16] = rd16(hdr, lim_s, l4_s);
            tuple[TUPLE_DPORT_LSB +: 16] = rd16(hdr, lim_s, l4_s + 7'd2);
         end else begin
            tuple[TUPLE_SPORT_LSB +: 16] = 16'h0000;
            tuple[TUPLE_DPORT_LSB +: 16] = 16'h0000;
         end
      end else begin
         tuple = {TUPLE_WIDTH{1'b0}};
      end

      flags[F_VLAN_Q]  = vlan_q_s;
      flags[F_VLAN_AD] = vlan_ad_s;
   end

endmodule

// File: rtl/pkt_attr_extractor.sv
// pkt_attr_extractor: passive tap on a 256-bit AXI4-Stream that captures
// the first 64 bytes of each packet, decodes them and emits one attribute
// word per packet with a single-cycle valid pulse. Never backpressures.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   s_axis_*        observed stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   pkt_attributes  out 135  {src one-hot, 2'b0, flags, length, tuple}
//   pkt_valid       out 1    one pulse per packet, two cycles after the
//                            last captured header beat
module pkt_attr_extractor
   import pkt_attr_extractor_pkg::*;
(
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [ATTRIBUTE_DATA_WIDTH-1:0] pkt_attributes,
   output logic                            pkt_valid
);

   cap_state_t                   state_r;
   cap_state_t                   state_nxt_s;
   logic                         beat_s;
   logic                         parse_go_nxt_s;
   logic                         parse_go_r;
   logic [HDR_WIDTH-1:0]         hdr_r;
   logic [23:0]                  meta_r;
   logic [NUM_FLAGS-1:0]         flags_s;
   logic [TUPLE_WIDTH-1:0]       tuple_s;
   logic                         unused_inputs_s;

   // Byte enables and upper tuser bits carry nothing the decoder needs.
   assign unused_inputs_s = ^{s_axis_tkeep, s_axis_tuser[C_M_AXIS_TUSER_WIDTH-1:24]};
   assign beat_s          = s_axis_tvalid & s_axis_tready;

   // Capture FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_SOP;
         parse_go_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         parse_go_r <= parse_go_nxt_s;
      end
   end

   // Capture FSM next state; parse is launched once the header is complete.
   always_comb begin
      state_nxt_s    = state_r;
      parse_go_nxt_s = 1'b0;
      if (beat_s) begin
         case (state_r)
            ST_SOP: begin
               parse_go_nxt_s = s_axis_tlast;
               state_nxt_s    = s_axis_tlast ? ST_SOP : ST_BEAT1;
            end
            ST_BEAT1: begin
               parse_go_nxt_s = 1'b1;
               state_nxt_s    = s_axis_tlast ? ST_SOP : ST_WAIT_EOP;
            end
            ST_WAIT_EOP: begin
               state_nxt_s    = s_axis_tlast ? ST_SOP : ST_WAIT_EOP;
            end
            default: begin
               state_nxt_s    = ST_SOP;
            end
         endcase
      end else begin
         state_nxt_s    = state_r;
         parse_go_nxt_s = 1'b0;
      end
   end

   // Header buffer and per-packet metadata capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hdr_r  <= {HDR_WIDTH{1'b0}};
         meta_r <= 24'h00_0000;
      end else if (beat_s && (state_r == ST_SOP)) begin
         hdr_r[255:0] <= s_axis_tdata;
         meta_r       <= s_axis_tuser[23:0];
         // Single-beat packet: stale second-beat bytes must not be decoded.
         if (s_axis_tlast) begin
            hdr_r[511:256] <= {256{1'b0}};
         end else begin
            hdr_r[511:256] <= hdr_r[511:256];
         end
      end else if (beat_s && (state_r == ST_BEAT1)) begin
         hdr_r[511:256] <= s_axis_tdata;
      end else begin
         hdr_r  <= hdr_r;
         meta_r <= meta_r;
      end
   end

   // The buffer may be overwritten by the next packet on the same edge the
   // result is registered, so decode happens in the cycle right after go.
   pkt_hdr_parse u_parse (
      .hdr    (hdr_r),
      .length (meta_r[15:0]),
      .flags  (flags_s),
      .tuple  (tuple_s)
   );

   // Output register: attributes hold between pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_attributes <= {ATTRIBUTE_DATA_WIDTH{1'b0}};
         pkt_valid      <= 1'b0;
      end else begin
         pkt_valid <= parse_go_r;
         if (parse_go_r) begin
            pkt_attributes <= {meta_r[23:16], 2'b00, flags_s, meta_r[15:0], tuple_s};
         end else begin
            pkt_attributes <= pkt_attributes;
         end
      end
   end

endmodule
